// File: rtl/sha_nonce_scheduler_if.sv
// sha_nonce_scheduler_if: job control, hash-core handshake and result memory port of the nonce scheduler
interface sha_nonce_scheduler_if #(parameter int NUM_CORES = 4);
  logic start;
  logic [15:0] output_addr;
  logic done;
  logic busy;
  logic err;
  logic [NUM_CORES-1:0] core_start;
  logic [31:0] core_nonce;
  logic [NUM_CORES-1:0] core_done;
  logic [32*NUM_CORES-1:0] core_h0;
  logic mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  modport master (
    output start, output_addr, core_done, core_h0,
    input done, busy, err, core_start, core_nonce, mem_we, mem_addr, mem_write_data
  );
  modport slave (
    input start, output_addr, core_done, core_h0,
    output done, busy, err, core_start, core_nonce, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/sha_nonce_scheduler.sv
// sha_nonce_scheduler: round-robin nonce dispatch to a SHA-256 core pool with H0 write-back to memory
module sha_nonce_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int NUM_NONCES = 16
) (
  input logic clk,
  input logic reset_n,
  sha_nonce_scheduler_if.slave bus
);
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam logic [15:0] NN = 16'(NUM_NONCES);
  localparam logic [CW-1:0] LAST = CW'(NUM_CORES - 1);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [15:0] base, issued, written;
  logic [NUM_CORES-1:0] cbusy, pend, idle;
  logic [15:0] nonce_of [NUM_CORES];
  logic [31:0] res [NUM_CORES];
  logic [CW-1:0] rr_disp, rr_wr, disp_k, wr_k, idx;
  logic disp_ok, wr_ok, fin_ok, accept;
  function automatic logic [CW-1:0] nxt(input logic [CW-1:0] k);
    return k == LAST ? '0 : k + CW'(1);
  endfunction
  // Round-robin picks for dispatch and write-back, job completion and next state
  always_comb begin
    idle = ~cbusy & ~pend;
    disp_k = '0;
    wr_k = '0;
    disp_ok = 1'b0;
    wr_ok = 1'b0;
    idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx = CW'((int'(rr_disp) + i) % NUM_CORES);
      if (idle[idx]) begin
        disp_k = idx;
        disp_ok = state == RUN && issued < NN;
      end
      idx = CW'((int'(rr_wr) + i) % NUM_CORES);
      if (pend[idx]) begin
        wr_k = idx;
        wr_ok = state == RUN;
      end
    end
    fin_ok = written == NN && cbusy == '0 && pend == '0;
    accept = state == IDLE && bus.start;
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) :
              state == RUN  ? (fin_ok ? FIN : RUN) : IDLE;
  end
  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  // Per-core bookkeeping, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      bus.err <= 1'b0;
      bus.core_start <= '0;
      bus.core_nonce <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_write_data <= '0;
      base <= '0;
      issued <= '0;
      written <= '0;
      cbusy <= '0;
      pend <= '0;
      rr_disp <= '0;
      rr_wr <= '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        nonce_of[k] <= '0;
        res[k] <= '0;
      end
    end else begin
      bus.done <= state == RUN && fin_ok;
      bus.busy <= state == IDLE ? bus.start : state == RUN;
      bus.core_start <= disp_ok ? NUM_CORES'(1) << disp_k : '0;
      bus.core_nonce <= disp_ok ? {16'h0, issued} : '0;
      bus.mem_we <= wr_ok;
      bus.err <= accept ? 1'b0 : bus.err | (|(bus.core_done & ~cbusy));
      if (wr_ok) begin
        bus.mem_addr <= base + nonce_of[wr_k];
        bus.mem_write_data <= res[wr_k];
        pend[wr_k] <= 1'b0;
        written <= written + 16'd1;
        rr_wr <= nxt(wr_k);
      end
      if (disp_ok) begin
        cbusy[disp_k] <= 1'b1;
        nonce_of[disp_k] <= issued;
        issued <= issued + 16'd1;
        rr_disp <= nxt(disp_k);
      end
      for (int k = 0; k < NUM_CORES; k++) begin
        if (bus.core_done[k] && cbusy[k]) begin
          res[k] <= bus.core_h0[32*k +: 32];
          pend[k] <= 1'b1;
          cbusy[k] <= 1'b0;
        end
      end
      if (accept) begin
        base <= bus.output_addr;
        issued <= '0;
        written <= '0;
        rr_disp <= '0;
        rr_wr <= '0;
      end
    end
  end
endmodule
